// File: rtl/bcd_serial_subtractor_if.sv
// Valid/ready bundle for the digit-serial BCD subtractor.
// The master side drives operands and out_ready. The slave side returns the result.
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  err;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, err
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, err
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: DIFF = A - B - BIN, one digit per clock, LSD first.
// Optional invalid-digit flag is compiled in with `define BCD_CHECK_EN.
module bcd_serial_subtractor #(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {borrow_out, digit}. The low nibble is kept even for non-BCD inputs.
  function automatic logic [4:0] sub_digit(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bi);
    logic signed [5:0] t;
    t = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b00000, bi});
    if (t < 6'sd0) begin
      t = t + 6'sd10;
      return {1'b1, t[3:0]};
    end
    return {1'b0, t[3:0]};
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                borrow_q;
  logic                bout_q;
  logic [DATA_W-1:0]   diff_q;
  logic signed [DATA_W-1:0] unused_sign_chk;
  logic [DATA_W-1:0]   opa_p0;
  logic [DATA_W-1:0]   opb_p0;
  logic [4:0]          step;
  logic                accept;
  logic                retire;
  logic                last;

  assign unused_sign_chk = '0;
  assign accept = (state_q == IDLE) && bus.in_valid;
  assign retire = (state_q == DONE) && bus.out_ready;
  assign last   = (idx_q == LAST_IDX);
  assign step   = sub_digit(opa_p0[3:0], opb_p0[3:0], borrow_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    if (last)         state_d = DONE;
      DONE:    if (retire)       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Operand stage: latched at acceptance, then shifted so the current digit is always in the low nibble.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0 <= bus.a;
      opb_p0 <= bus.b;
    end else if (state_q == CALC) begin
      opa_p0 <= opa_p0 >> 4;
      opb_p0 <= opb_p0 >> 4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      borrow_q <= bus.bin;
    end else if (state_q == CALC) begin
      idx_q    <= last ? '0 : idx_q + 1'b1;
      borrow_q <= step[4];
    end
  end

  // Result stage: digits enter at the top and settle into place after DIGITS shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (state_q == CALC) begin
      diff_q <= (diff_q >> 4) | (DATA_W'(step[3:0]) << (DATA_W - 4));
      if (last) bout_q <= step[4];
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [DATA_W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor: directed vectors push expectations,
// a monitor pops and compares on every output handshake.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) dif ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(dif.diff), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(dif.diff), 32'(e.diff));
        check("bout", 32'(dif.bout), 32'(e.bout));
        check("err",  32'(dif.err),  32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int n;
    n = 0;
    while (!dif.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(dif.in_ready), 32'd1);
    dif.a        = a;
    dif.b        = b;
    dif.bin      = bi;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!dif.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                    input logic [W-1:0] ed, input logic eb, input logic bad);
    int lat;
    sb.push_back('{diff: ed, bout: eb, err: CHK & bad});
    accept(a, b, bi);
    wait_out(lat);
    check("latency", 32'(lat), 32'(DIGITS));
    tick();
  endtask

  initial begin
    logic [W-1:0] held_diff;
    logic         held_bout;
    int           lat;

    rst           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.bin       = 1'b0;
    dif.out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready",  32'(dif.in_ready),  32'd1);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_diff",      32'(dif.diff),      32'd0);
    check("rst_bout",      32'(dif.bout),      32'd0);
    check("rst_err",       32'(dif.err),       32'd0);
    rst = 1'b0;
    tick();

    op(8'h45, 8'h17, 1'b0, 8'h28, 1'b0, 1'b0);
    op(8'h17, 8'h45, 1'b0, 8'h72, 1'b1, 1'b0);
    op(8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0);
    op(8'h99, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
    op(8'h3A, 8'h01, 1'b0, 8'h39, 1'b0, 1'b1);

    // Back-pressure: result must hold while in_valid pulses are ignored.
    dif.out_ready = 1'b0;
    sb.push_back('{diff: 8'h30, bout: 1'b0, err: 1'b0});
    accept(8'h50, 8'h20, 1'b0);
    wait_out(lat);
    check("stall_latency", 32'(lat), 32'(DIGITS));
    held_diff = dif.diff;
    held_bout = dif.bout;
    for (int i = 0; i < 5; i++) begin
      dif.a        = 8'h99;
      dif.b        = 8'h11;
      dif.in_valid = (i % 2 == 0);
      tick();
      check("stall_diff",      32'(dif.diff),      32'(held_diff));
      check("stall_bout",      32'(dif.bout),      32'(held_bout));
      check("stall_out_valid", 32'(dif.out_valid), 32'd1);
      check("stall_in_ready",  32'(dif.in_ready),  32'd0);
    end
    dif.in_valid  = 1'b1;
    dif.out_ready = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    check("retire_in_ready",  32'(dif.in_ready),  32'd1);
    check("retire_out_valid", 32'(dif.out_valid), 32'd0);
    tick();
    check("no_queued_accept", 32'(dif.in_ready), 32'd1);

    // Reset during CALC drops the transaction.
    accept(8'h17, 8'h45, 1'b0);
    check("calc_in_ready", 32'(dif.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  32'(dif.in_ready),  32'd1);
    check("abort_out_valid", 32'(dif.out_valid), 32'd0);
    check("abort_diff",      32'(dif.diff),      32'd0);
    check("abort_bout",      32'(dif.bout),      32'd0);

    op(8'h05, 8'h09, 1'b0, 8'h96, 1'b1, 1'b0);
    op(8'h10, 8'h01, 1'b1, 8'h08, 1'b0, 1'b0);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
